// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered one-hot grant and a hold timeout.
// Define RR_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest) instead of round-robin.
//
// state | meaning
// IDLE  | no grant outstanding, gnt = 0000
// GRANT | exactly one gnt bit set, hold_cnt counts consecutive held cycles
module rr_arbiter4 #(
   parameter int HOLD_MAX = 8,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   state_t           state, state_n;
   logic [3:0]       gnt_n;
   logic [1:0]       gnt_idx_n;
   logic [1:0]       last, last_n;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
   logic             timeout_n;

   logic [1:0]       scan_start;
   logic             win_found;
   logic [1:0]       win_idx;

   // First set request found walking upward from start, wrapping modulo 4.
   function automatic logic [2:0] scan(input logic [3:0] r, input logic [1:0] start);
      logic       found;
      logic [1:0] idx;
      logic [1:0] cand;
      found = 1'b0;
      idx   = 2'd0;
      for (int i = 0; i < 4; i++) begin
         cand = start + 2'(i);
         if (!found && r[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   always_comb begin
      scan_start = 2'd0;
`ifdef RR_ARB_FIXED_PRIO_EN
      scan_start = 2'd0;
`else
      // While granted, the current holder is about to become "last".
      if (state == GRANT) scan_start = gnt_idx + 2'd1;
      else                scan_start = last + 2'd1;
`endif
      {win_found, win_idx} = scan(req, scan_start);
   end

   always_comb begin
      state_n    = state;
      gnt_n      = gnt;
      gnt_idx_n  = gnt_idx;
      last_n     = last;
      hold_cnt_n = hold_cnt;
      timeout_n  = 1'b0;
      case (state)
         IDLE: begin
            if (win_found) begin
               state_n    = GRANT;
               gnt_n      = 4'b0001 << win_idx;
               gnt_idx_n  = win_idx;
               hold_cnt_n = '0;
            end
         end
         GRANT: begin
            if (req[gnt_idx] && (hold_cnt < HOLD_LAST)) begin
               hold_cnt_n = hold_cnt + 1'b1;
            end else begin
               // Release or expiry: hand over in the same edge, no idle gap.
               timeout_n  = req[gnt_idx];
               last_n     = gnt_idx;
               hold_cnt_n = '0;
               if (win_found) begin
                  gnt_n     = 4'b0001 << win_idx;
                  gnt_idx_n = win_idx;
               end else begin
                  state_n = IDLE;
                  gnt_n   = 4'b0000;
               end
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= 4'b0000;
         gnt_idx  <= 2'd0;
         last     <= 2'd3;
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_n;
         gnt      <= gnt_n;
         gnt_idx  <= gnt_idx_n;
         last     <= last_n;
         hold_cnt <= hold_cnt_n;
         timeout  <= timeout_n;
      end
   end

   assign gnt_valid = |gnt;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 with HOLD_MAX=4; expected values are hand-computed.
module tb_rr_arbiter4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   int n_checks = 0;
   int n_pass   = 0;

   rr_arbiter4 #(.HOLD_MAX(4), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_idx,
                            input logic e_to);
      check({tag, ".gnt"}, 8'(gnt), 8'(e_gnt));
      check({tag, ".idx"}, 8'(gnt_idx), 8'(e_idx));
      check({tag, ".valid"}, 8'(gnt_valid), 8'(e_gnt != 4'b0000));
      check({tag, ".timeout"}, 8'(timeout), 8'(e_to));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 4'b0000;
      step();
      rst = 1'b0;
   endtask

   logic [3:0] e_gnt;
   logic [1:0] e_idx;

   initial begin
      rst = 1'b0;
      req = 4'b0000;

      // Reset state and idle with no requests.
      do_reset();
      check_out("reset", 4'b0000, 2'd0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step();
         check_out("idle", 4'b0000, 2'd0, 1'b0);
      end

      // Single requester held three cycles, then released; idx holds.
      req = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         step();
         check_out("single", 4'b0100, 2'd2, 1'b0);
      end
      req = 4'b0000;
      step();
      check_out("single_rel", 4'b0000, 2'd2, 1'b0);

      // All four requesting: rotation with timeout at each handover.
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 20; k++) begin
         step();
`ifdef RR_ARB_FIXED_PRIO_EN
         e_idx = 2'd0;
`else
         e_idx = 2'((k / 4) % 4);
`endif
         e_gnt = 4'b0001 << e_idx;
         check_out("rotate", e_gnt, e_idx, (k % 4 == 0) && (k > 0));
      end

      // Client 1 drops while 0 and 3 arrive: scan from 2 picks 3.
      do_reset();
      req = 4'b0010;
      step();
      check_out("c1_grant", 4'b0010, 2'd1, 1'b0);
      req = 4'b1001;
      step();
`ifdef RR_ARB_FIXED_PRIO_EN
      check_out("c1_handover", 4'b0001, 2'd0, 1'b0);
`else
      check_out("c1_handover", 4'b1000, 2'd3, 1'b0);
`endif
      req = 4'b0001;
      step();
      check_out("c3_handover", 4'b0001, 2'd0, 1'b0);
      req = 4'b0000;
      step();
      check_out("c0_release", 4'b0000, 2'd0, 1'b0);

      // Sole requester: re-granted on expiry, timeout every 4th cycle.
      do_reset();
      req = 4'b0001;
      for (int k = 0; k < 10; k++) begin
         step();
         check_out("sole", 4'b0001, 2'd0, (k % 4 == 0) && (k > 0));
      end

      // Reset mid-grant drops the grant; pointer returns to 3.
      do_reset();
      req = 4'b0100;
      step();
      check_out("pre_rst", 4'b0100, 2'd2, 1'b0);
      step();
      rst = 1'b1;
      step();
      check_out("mid_rst", 4'b0000, 2'd0, 1'b0);
      rst = 1'b0;
      req = 4'b0101;
      step();
      check_out("post_rst", 4'b0001, 2'd0, 1'b0);
      req = 4'b0100;
      step();
      check_out("post_rst_next", 4'b0100, 2'd2, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource, such as the 4-to-2 encoder path, among four clients.
- Produces a registered one-hot grant and its 2-bit encoded index, using the same 4:2 encoding as encode42 (0001->00, 0010->01, 0100->10, 1000->11).
- A hold timeout prevents any client from monopolising the resource.
- Sits between client request lines and the shared datapath select.

Parameters:
- HOLD_MAX, 8, maximum consecutive cycles one grant may be held; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; req[i]=1 means client i wants the resource.
- gnt  output  4  one-hot grant, registered; 0000 when idle.
- gnt_idx  output  2  encoded index of the granted client, registered.
- gnt_valid  output  1  high while any grant is active (equals |gnt).
- timeout  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX expiry.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, gnt=0000, gnt_idx=00, gnt_valid=0, timeout=0, hold_cnt=0.
  - Priority pointer last=3, so client 0 has top priority after reset.
  - Reset mid-grant drops the grant on the next edge regardless of req.
- States:
  - IDLE: no grant.
  - GRANT: exactly one gnt bit set.
- Arbitration function:
  - Scan from (last+1) mod 4 upward with wrap-around.
  - The first set req bit wins.
  - The winner is registered into gnt/gnt_idx; last is not updated at grant time.
- IDLE -> GRANT: any req bit set at an edge gives gnt valid after that edge (1-cycle latency). hold_cnt=0.
- GRANT, hold: req[gnt_idx]=1 and hold_cnt<HOLD_MAX-1 -> stay in GRANT, hold_cnt+=1, outputs unchanged.
- GRANT, release: req[gnt_idx]=0 at an edge.
  - last<=gnt_idx.
  - Re-arbitrate in the same edge from pointer gnt_idx+1, so there is no idle gap.
  - If no req is set -> IDLE, gnt=0000, gnt_idx holds its last value.
- GRANT, expiry: req[gnt_idx]=1 and hold_cnt==HOLD_MAX-1.
  - timeout=1 for one cycle, last<=gnt_idx, re-arbitrate as for release.
  - The current client then has lowest priority.
  - If it is the only requester, it is re-granted with hold_cnt=0 (timeout still pulses).
- New requests arriving during GRANT never preempt the current grant.
- Multiple simultaneous requests are resolved only by the pointer order.
- Arithmetic:
  - Pointer and index arithmetic is 2-bit modulo 4.
  - hold_cnt saturates at HOLD_MAX-1 and never wraps.
  - HOLD_MAX=1 means each grant lasts exactly one cycle while contended.
- Invariants: gnt is always 0000 or one-hot; gnt_idx equals the encode of gnt whenever gnt_valid=1.

Optional Feature:
- Macro: RR_ARB_FIXED_PRIO_EN.
- Defined:
  - Fixed priority; req[0] is highest and req[3] lowest.
  - The pointer is unused, and the scan always starts at 0.
  - The hold/timeout logic is unchanged. On expiry the highest-priority active requester wins, which may be the same client.
- Undefined: round-robin as described above.

Test Plan:
- Reset then req=0000 for 5 cycles -> gnt=0000, gnt_valid=0, gnt_idx=00, timeout=0 throughout.
- req=0100 at cycle 1, held 3 cycles, then 0000 -> gnt=0100, gnt_idx=10 from cycle 2 for 3 cycles, then gnt=0000.
- req=1111 held continuously, HOLD_MAX=4:
  - Grants rotate 0001, 0010, 0100, 1000, 0001, 4 cycles each.
  - timeout pulses at each handover.
  - No idle cycle between grants.
- Client 1 granted, req changes from 0010 to 1001 in the same cycle client 1 drops:
  - Next grant is 1000 (idx 11), since the scan starts at 2.
  - After client 3 drops, the grant goes to 0001.
- Sole requester req=0001 held for 10 cycles, HOLD_MAX=4 -> gnt stays 0001, timeout pulses every 4th cycle, gnt_valid never drops.
- rst asserted while gnt=0100 with req=0100 still high:
  - gnt=0000 the next cycle.
  - After rst deasserts with req=0101, the grant goes to 0001 (pointer reset to 3).
  - With RR_ARB_FIXED_PRIO_EN defined and req=1111, gnt is always 0001.
